// File: rtl/ivs_mst.sv
// ivs_mst: single-outstanding command-to-AHB-Lite bridge master.
// Commands are accepted one at a time, issued as a single NONSEQ word
// transfer, and answered with one response carrying read data and an
// error flag (misaligned, slave error or bus-stall timeout).
module ivs_mst #(
  parameter int unsigned TO_CYC = 255
) (
  input  logic        hclk,
  input  logic        hrst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        hsel,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [31:0] haddr,
  output logic [31:0] hwdata,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic [3:0]  hprot,
  output logic        hready_in,
  input  logic        hready,
  input  logic [1:0]  hresp,
  input  logic [31:0] hrdata,
  output logic [7:0]  err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10,
    RESP = 2'b11
  } state_t;

  localparam logic [7:0] TO_LIM = 8'(TO_CYC);

  state_t      state_r, state_s;
  logic [7:0]  to_cnt_r, to_cnt_s;
  logic [7:0]  stall_s;
  logic        accept_s;
  logic        rsp_load_s;
  logic [31:0] rsp_rdata_s;
  logic        rsp_err_s;
  logic        cmd_write_r;
  logic [31:0] cmd_wdata_r;
  logic        unused_s;

  // Word transfers, single bursts, privileged data access only.
  assign hsize     = 3'b010;
  assign hburst    = 3'b000;
  assign hprot     = 4'b0011;
  assign hready_in = hready;
  assign stall_s   = to_cnt_r + 8'd1;
  assign unused_s  = hresp[1];

  // Next-state, stall timeout and response capture decisions.
  always_comb begin
    state_s     = state_r;
    to_cnt_s    = to_cnt_r;
    accept_s    = 1'b0;
    rsp_load_s  = 1'b0;
    rsp_rdata_s = 32'h0000_0000;
    rsp_err_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cmd_valid) begin
          accept_s = 1'b1;
          if (cmd_addr[1:0] != 2'b00) begin
            state_s    = RESP;
            rsp_load_s = 1'b1;
            rsp_err_s  = 1'b1;
          end else begin
            state_s  = ADDR;
            to_cnt_s = 8'd0;
          end
        end else begin
          state_s = IDLE;
        end
      end
      ADDR: begin
        if (hready) begin
          state_s = DATA;
        end else if (stall_s == TO_LIM) begin
          state_s    = RESP;
          to_cnt_s   = stall_s;
          rsp_load_s = 1'b1;
          rsp_err_s  = 1'b1;
        end else begin
          to_cnt_s = stall_s;
        end
      end
      DATA: begin
        if (hready) begin
          state_s    = RESP;
          rsp_load_s = 1'b1;
          rsp_err_s  = hresp[0];
          // Read data is only meaningful for a successful read.
          if (!cmd_write_r && !hresp[0]) begin
            rsp_rdata_s = hrdata;
          end else begin
            rsp_rdata_s = 32'h0000_0000;
          end
        end else if (stall_s == TO_LIM) begin
          state_s    = RESP;
          to_cnt_s   = stall_s;
          rsp_load_s = 1'b1;
          rsp_err_s  = 1'b1;
        end else begin
          to_cnt_s = stall_s;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, command latch and registered bus/response outputs.
  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_r     <= IDLE;
      to_cnt_r    <= 8'd0;
      cmd_ready   <= 1'b1;
      cmd_write_r <= 1'b0;
      cmd_wdata_r <= 32'h0000_0000;
      hsel        <= 1'b0;
      htrans      <= 2'b00;
      hwrite      <= 1'b0;
      haddr       <= 32'h0000_0000;
      hwdata      <= 32'h0000_0000;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'h0000_0000;
      rsp_err     <= 1'b0;
      err_cnt     <= 8'd0;
    end else begin
      state_r   <= state_s;
      to_cnt_r  <= to_cnt_s;
      cmd_ready <= (state_s == IDLE);
      hsel      <= (state_s == ADDR);
      htrans    <= (state_s == ADDR) ? 2'b10 : 2'b00;
      rsp_valid <= (state_s == RESP);
      if (accept_s) begin
        cmd_write_r <= cmd_write;
        cmd_wdata_r <= cmd_wdata;
      end
      // Address-phase signals only change for a transfer that goes on the bus.
      if (state_s == ADDR && state_r == IDLE) begin
        haddr  <= cmd_addr;
        hwrite <= cmd_write;
      end
      // Write data is presented for the whole data phase and held afterwards.
      if (state_s == DATA && state_r == ADDR) begin
        hwdata <= cmd_wdata_r;
      end
      if (rsp_load_s) begin
        rsp_rdata <= rsp_rdata_s;
        rsp_err   <= rsp_err_s;
      end
      if (state_r == RESP && rsp_ready && rsp_err && err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_ivs_mst.sv
// tb_ivs_mst: randomized bench for ivs_mst with a transaction-timeline model
// of the master and a behavioural word-memory slave.
module tb_ivs_mst;

  localparam int TO = 4;

  logic        hclk = 1'b0;
  logic        hrst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [31:0] cmd_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        hsel;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic        hready_in;
  logic        hready = 1'b1;
  logic [1:0]  hresp = 2'b00;
  logic [31:0] hrdata = 32'h0;
  logic [7:0]  err_cnt;

  ivs_mst #(.TO_CYC(TO)) dut (
    .hclk(hclk), .hrst(hrst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .hsel(hsel), .htrans(htrans), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
    .hsize(hsize), .hburst(hburst), .hprot(hprot), .hready_in(hready_in),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .err_cnt(err_cnt)
  );

  always #5 hclk = ~hclk;

  int errors = 0;
  int checks = 0;

  // Expected values for the current cycle, maintained by the driver.
  logic        chk_en = 1'b0;
  logic        exp_cmd_ready = 1'b1;
  logic        exp_rsp_valid = 1'b0;
  logic [31:0] exp_rdata = 32'h0;
  logic        exp_err = 1'b0;
  logic [1:0]  exp_htrans = 2'b00;
  logic        exp_hsel = 1'b0;
  logic        chk_addr = 1'b0;
  logic [31:0] exp_haddr = 32'h0;
  logic        exp_hwrite = 1'b0;
  logic [31:0] exp_hwdata = 32'h0;
  logic [7:0]  exp_err_cnt = 8'd0;

  // Slave memory contents.
  logic [31:0] mem [logic [31:0]];

  // Observations used by the literal checks.
  int          cyc = 0;
  int          acc_cyc = 0;
  int          obs_lat = -1;
  logic        rv_prev = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return ~a;
  endfunction

  // Compare process: every cycle, away from the rising edge.
  always @(negedge hclk) begin
    cyc++;
    if (cmd_valid && cmd_ready) acc_cyc = cyc;
    if (rsp_valid && !rv_prev) obs_lat = cyc - acc_cyc;
    rv_prev = rsp_valid;
    if (rsp_valid) last_rdata = rsp_rdata;
    if (chk_en && !hrst) begin
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_cmd_ready));
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_rsp_valid));
      chk("htrans", 32'(htrans), 32'(exp_htrans));
      chk("hsel", 32'(hsel), 32'(exp_hsel));
      chk("hwdata", hwdata, exp_hwdata);
      chk("err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
      chk("hready_in", 32'(hready_in), 32'(hready));
      chk("hfixed", 32'({hsize, hburst, hprot}), 32'({3'b010, 3'b000, 4'b0011}));
      if (chk_addr) begin
        chk("haddr", haddr, exp_haddr);
        chk("hwrite", 32'(hwrite), 32'(exp_hwrite));
      end
      if (exp_rsp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
      end
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic noise();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_write = 1'($urandom_range(0, 1));
    cmd_addr  = $urandom;
    cmd_wdata = $urandom;
  endtask

  task automatic slave_idle();
    hready = 1'($urandom_range(0, 1));
    hresp  = 2'($urandom_range(0, 3));
    hrdata = $urandom;
  endtask

  // Asserts reset at the current instant, checks the immediate clear, releases it.
  task automatic do_reset();
    chk_en = 1'b0;
    hrst = 1'b1;
    cmd_valid = 1'b0;
    #1;
    chk("rst_htrans", 32'(htrans), 32'h0);
    chk("rst_hsel", 32'(hsel), 32'h0);
    chk("rst_haddr", haddr, 32'h0);
    chk("rst_hwrite", 32'(hwrite), 32'h0);
    chk("rst_hwdata", hwdata, 32'h0);
    chk("rst_rsp", 32'({rsp_valid, rsp_err}), 32'h0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err_cnt", 32'(err_cnt), 32'h0);
    tick();
    tick();
    hrst = 1'b0;
    exp_cmd_ready = 1'b1;
    exp_rsp_valid = 1'b0;
    exp_htrans = 2'b00;
    exp_hsel = 1'b0;
    exp_hwdata = 32'h0;
    exp_err_cnt = 8'd0;
    chk_addr = 1'b1;
    exp_haddr = 32'h0;
    exp_hwrite = 1'b0;
    chk_en = 1'b1;
  endtask

  // One command: gap idle cycles, accept, a address-phase waits, d data-phase
  // waits, optional slave error, hold cycles of response backpressure.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int a, input int d, input logic berr, input int hold, input int gap);
    int          addr_cyc;
    int          data_cyc;
    logic        tmo;
    logic [31:0] rd;
    logic        e;
    for (int i = 0; i < gap; i++) begin
      cmd_valid = 1'b0;
      slave_idle();
      tick();
    end
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wd;
    slave_idle();
    tick();
    noise();
    exp_cmd_ready = 1'b0;
    chk_addr = 1'b0;
    if (addr[1:0] != 2'b00) begin
      rd = 32'h0;
      e  = 1'b1;
    end else begin
      tmo = (a + d >= TO);
      if (a >= TO) begin
        addr_cyc = TO;
        data_cyc = 0;
      end else begin
        addr_cyc = a + 1;
        data_cyc = tmo ? (TO - a) : (d + 1);
      end
      for (int k = 1; k <= addr_cyc; k++) begin
        exp_htrans = 2'b10;
        exp_hsel   = 1'b1;
        chk_addr   = 1'b1;
        exp_haddr  = addr;
        exp_hwrite = wr;
        slave_idle();
        hready = (k == a + 1);
        tick();
        noise();
      end
      exp_htrans = 2'b00;
      exp_hsel   = 1'b0;
      chk_addr   = 1'b0;
      if (data_cyc > 0) exp_hwdata = wd;
      for (int j = 1; j <= data_cyc; j++) begin
        slave_idle();
        hready = (j == d + 1);
        if (j == d + 1) begin
          hresp  = {1'b0, berr};
          hrdata = wr ? $urandom : rd_mem(addr);
        end
        tick();
        noise();
      end
      if (tmo || berr) begin
        rd = 32'h0;
        e  = 1'b1;
      end else begin
        rd = wr ? 32'h0 : rd_mem(addr);
        e  = 1'b0;
        if (wr) mem[addr] = wd;
      end
    end
    for (int h = 0; h <= hold; h++) begin
      exp_rsp_valid = 1'b1;
      exp_rdata = rd;
      exp_err = e;
      slave_idle();
      rsp_ready = (h == hold);
      tick();
      noise();
    end
    cmd_valid = 1'b0;
    exp_rsp_valid = 1'b0;
    exp_cmd_ready = 1'b1;
    if (e && exp_err_cnt != 8'hFF) exp_err_cnt = exp_err_cnt + 8'd1;
  endtask

  initial begin
    logic        wr;
    logic [31:0] ad;
    int          a;
    int          d;
    #2;
    do_reset();
    tick();

    // Zero-wait write.
    do_txn(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, 0, 0, 1'b0, 0, 1);
    chk("lat_write", 32'(obs_lat), 32'd3);
    do_txn(1'b1, 32'h0000_0104, 32'h1234_5678, 0, 0, 1'b0, 0, 0);
    // Read with the slave's registered-data wait state.
    do_txn(1'b0, 32'h0000_0104, 32'h0, 0, 1, 1'b0, 0, 1);
    chk("lat_read", 32'(obs_lat), 32'd4);
    chk("rd_data_lit", last_rdata, 32'h1234_5678);
    // Misaligned command.
    do_txn(1'b0, 32'h0000_0102, 32'h0, 0, 1, 1'b0, 0, 0);
    chk("err_cnt_one", 32'(err_cnt), 32'd1);
    // Address phase stalled past the timeout, then a normal command.
    do_txn(1'b1, 32'h0000_0200, 32'h5555_AAAA, 10, 0, 1'b0, 0, 0);
    chk("lat_timeout", 32'(obs_lat), 32'(TO + 1));
    do_txn(1'b0, 32'h0000_0104, 32'h0, 0, 1, 1'b0, 0, 0);
    chk("rd_after_to", last_rdata, 32'h1234_5678);
    // Long response backpressure.
    do_txn(1'b0, 32'h0000_0104, 32'h0, 0, 1, 1'b0, 10, 0);
    chk("err_cnt_two", 32'(err_cnt), 32'd2);

    // Randomized traffic.
    for (int n = 0; n < 200; n++) begin
      wr = 1'($urandom_range(0, 1));
      ad = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 7) == 0) ad[1:0] = 2'($urandom_range(1, 3));
      a = ($urandom_range(0, 9) == 0) ? $urandom_range(4, 6) : $urandom_range(0, 2);
      d = $urandom_range(0, 3) + (wr ? 0 : 1);
      do_txn(wr, ad, $urandom, a, d, ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
             $urandom_range(0, 2));
    end

    // Reset in the middle of a stalled write data phase.
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 32'h0000_0300;
    cmd_wdata = 32'hCAFE_F00D;
    hready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    exp_cmd_ready = 1'b0;
    exp_htrans = 2'b10;
    exp_hsel = 1'b1;
    chk_addr = 1'b1;
    exp_haddr = 32'h0000_0300;
    exp_hwrite = 1'b1;
    tick();
    exp_htrans = 2'b00;
    exp_hsel = 1'b0;
    chk_addr = 1'b0;
    exp_hwdata = 32'hCAFE_F00D;
    hready = 1'b0;
    chk("hwdata_pre_rst", hwdata, 32'hCAFE_F00D);
    #2;
    do_reset();
    hready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("no_rsp_after_rst", 32'(obs_lat == -1 || rsp_valid == 1'b0), 32'd1);

    // Force the error counter into saturation.
    for (int n = 0; n < 256; n++) begin
      do_txn(1'($urandom_range(0, 1)), 32'h0000_0401, $urandom, 0, 0, 1'b0, 0, 0);
    end
    chk("err_cnt_sat", 32'(err_cnt), 32'd255);
    do_txn(1'b0, 32'h0000_0403, 32'h0, 0, 0, 1'b0, 0, 0);
    chk("err_cnt_hold", 32'(err_cnt), 32'd255);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
